// File: rtl/emu_ctrl_gen.sv
// emu_ctrl_gen: emulator run-control block.
// A small HOLD/IDLE/RUN FSM generates the reset and run controls for an emulated
// design, and N_CH decimation channels emit one-cycle strobes while running.
// A host configures the block through a single-beat write port.
//
// Config handshake: a write takes effect on a rising edge where
// cfg_valid && cfg_ready. cfg_ready depends only on the FSM state: high in
// IDLE and RUN, low in HOLD. It never depends on cfg_valid. The host holds
// cfg_valid, cfg_addr and cfg_data stable until it sees cfg_ready.
// The FSM state is visible on the outputs: HOLD = emu_rst, RUN = emu_run,
// IDLE = neither.
module emu_ctrl_gen #(
  parameter int N_CH         = 2,
  parameter int DEC_BITS     = 16,
  parameter int RST_CYCLES   = 8,
  parameter int DEC_THR_INIT = 0
) (
  input  logic                     emu_clk,
  input  logic                     emu_rst_n,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [3:0]               cfg_addr,
  input  logic [DEC_BITS-1:0]      cfg_data,
  output logic                     emu_rst,
  output logic                     emu_run,
  output logic [N_CH*DEC_BITS-1:0] emu_dec_thr,
  output logic [N_CH-1:0]          dec_stb
);

  localparam int HW = $clog2(RST_CYCLES + 1);
  localparam logic [DEC_BITS-1:0] THR_INIT = DEC_BITS'(DEC_THR_INIT);

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_IDLE = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t                           state_q, state_d;
  logic [HW-1:0]                    hold_cnt_q, hold_cnt_d;
  logic                             run_req_q, run_req_d;
  logic [N_CH-1:0][DEC_BITS-1:0]    thr_q, thr_d;
  logic [N_CH-1:0][DEC_BITS-1:0]    cnt_q, cnt_d;
  logic [N_CH-1:0]                  dec_stb_q, dec_stb_d;
  logic                             emu_rst_q, emu_rst_d;
  logic                             emu_run_q, emu_run_d;
  logic                             cfg_ready_q, cfg_ready_d;
  logic                             cfg_wr;

  assign cfg_ready   = cfg_ready_q;
  assign emu_rst     = emu_rst_q;
  assign emu_run     = emu_run_q;
  assign dec_stb     = dec_stb_q;
  assign emu_dec_thr = thr_q;

  // Next-state, counter, threshold and registered-output computation.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    run_req_d  = run_req_q;
    thr_d      = thr_q;
    cnt_d      = cnt_q;
    cfg_wr     = cfg_valid && cfg_ready_q;

    case (state_q)
      ST_HOLD: begin
        cnt_d = '0;
        if (hold_cnt_q == HW'(RST_CYCLES - 1)) begin
          hold_cnt_d = '0;
          state_d    = run_req_q ? ST_RUN : ST_IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      ST_RUN: begin
        // A counter at or above its threshold strobes this cycle and restarts at
        // zero. That covers a threshold lowered under the running count.
        for (int k = 0; k < N_CH; k++) begin
          cnt_d[k] = (cnt_q[k] >= thr_q[k]) ? '0 : cnt_q[k] + DEC_BITS'(1);
        end
      end
      default: ;
    endcase

    if (cfg_wr) begin
      if (cfg_addr == 4'd0) begin
        run_req_d = cfg_data[1];
        if (cfg_data[0]) begin
          state_d    = ST_HOLD;
          hold_cnt_d = '0;
          cnt_d      = '0;
        end else begin
          state_d = cfg_data[1] ? ST_RUN : ST_IDLE;
        end
      end
      for (int k = 0; k < N_CH; k++) begin
        if (cfg_addr == 4'(k + 1)) thr_d[k] = cfg_data;
      end
    end

    // The strobe register holds the comparison for the counter value of the
    // coming cycle, so dec_stb lines up with the count it belongs to.
    for (int k = 0; k < N_CH; k++) begin
      dec_stb_d[k] = (state_d == ST_RUN) && (cnt_d[k] >= thr_d[k]);
    end
    emu_rst_d   = (state_d == ST_HOLD);
    emu_run_d   = (state_d == ST_RUN);
    cfg_ready_d = (state_d != ST_HOLD);
  end

  // State and output registers; the hardware reset forces HOLD at once.
  always_ff @(posedge emu_clk or negedge emu_rst_n) begin
    if (!emu_rst_n) begin
      state_q     <= ST_HOLD;
      hold_cnt_q  <= '0;
      run_req_q   <= 1'b0;
      thr_q       <= {N_CH{THR_INIT}};
      cnt_q       <= '0;
      dec_stb_q   <= '0;
      emu_rst_q   <= 1'b1;
      emu_run_q   <= 1'b0;
      cfg_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      run_req_q   <= run_req_d;
      thr_q       <= thr_d;
      cnt_q       <= cnt_d;
      dec_stb_q   <= dec_stb_d;
      emu_rst_q   <= emu_rst_d;
      emu_run_q   <= emu_run_d;
      cfg_ready_q <= cfg_ready_d;
    end
  end

endmodule

// File: tb/tb_emu_ctrl_gen.sv
// tb_emu_ctrl_gen: directed vector table, hand-written corner sequences, and
// random traffic checked cycle by cycle against a rule-level model of emu_ctrl_gen.
module tb_emu_ctrl_gen;

  localparam int N_CH       = 2;
  localparam int DEC_BITS   = 16;
  localparam int RST_CYCLES = 8;
  localparam int W          = 3 + N_CH + N_CH * DEC_BITS;
  localparam int M_HOLD = 0, M_IDLE = 1, M_RUN = 2;

  logic                     emu_clk;
  logic                     emu_rst_n;
  logic                     cfg_valid;
  logic                     cfg_ready;
  logic [3:0]               cfg_addr;
  logic [DEC_BITS-1:0]      cfg_data;
  logic                     emu_rst;
  logic                     emu_run;
  logic [N_CH*DEC_BITS-1:0] emu_dec_thr;
  logic [N_CH-1:0]          dec_stb;

  emu_ctrl_gen #(
    .N_CH(N_CH), .DEC_BITS(DEC_BITS), .RST_CYCLES(RST_CYCLES), .DEC_THR_INIT(0)
  ) dut (
    .emu_clk(emu_clk), .emu_rst_n(emu_rst_n), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .emu_rst(emu_rst), .emu_run(emu_run), .emu_dec_thr(emu_dec_thr),
    .dec_stb(dec_stb)
  );

  // Clock and watchdog.
  initial emu_clk = 1'b0;
  always #5 emu_clk = ~emu_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard state.
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  // Reference model: operating mode, remaining hold cycles, run request,
  // per-channel thresholds and counts, held as plain integers.
  int m_mode;
  int m_hold_left;
  bit m_run_req;
  int m_thr[N_CH];
  int m_cnt[N_CH];

  function automatic logic [W-1:0] model_expect();
    logic [N_CH-1:0] stb;
    logic [N_CH*DEC_BITS-1:0] thr;
    for (int k = 0; k < N_CH; k++) begin
      stb[k] = (m_mode == M_RUN) && (m_cnt[k] >= m_thr[k]);
      thr[k*DEC_BITS +: DEC_BITS] = DEC_BITS'(m_thr[k]);
    end
    return {(m_mode == M_HOLD), (m_mode == M_RUN), (m_mode != M_HOLD), stb, thr};
  endfunction

  function automatic logic [W-1:0] dut_outputs();
    return {emu_rst, emu_run, cfg_ready, dec_stb, emu_dec_thr};
  endfunction

  task automatic model_reset();
    m_mode      = M_HOLD;
    m_hold_left = RST_CYCLES;
    m_run_req   = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      m_thr[k] = 0;
      m_cnt[k] = 0;
    end
    exp_q.delete();
  endtask

  // One rising edge of the model with the inputs present at that edge.
  task automatic model_edge(input logic v, input logic [3:0] a, input logic [DEC_BITS-1:0] d);
    bit accepted;
    accepted = v && (m_mode != M_HOLD);
    if (m_mode == M_HOLD) begin
      for (int k = 0; k < N_CH; k++) m_cnt[k] = 0;
      m_hold_left--;
      if (m_hold_left == 0) m_mode = m_run_req ? M_RUN : M_IDLE;
    end else if (m_mode == M_RUN) begin
      for (int k = 0; k < N_CH; k++) m_cnt[k] = (m_cnt[k] >= m_thr[k]) ? 0 : m_cnt[k] + 1;
    end
    if (accepted) begin
      if (a == 4'd0) begin
        m_run_req = d[1];
        if (d[0]) begin
          m_mode      = M_HOLD;
          m_hold_left = RST_CYCLES;
          for (int k = 0; k < N_CH; k++) m_cnt[k] = 0;
        end else begin
          m_mode = m_run_req ? M_RUN : M_IDLE;
        end
      end else if (int'(a) <= N_CH) begin
        m_thr[int'(a) - 1] = int'(d);
      end
    end
    exp_q.push_back(model_expect());
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Driver: present inputs, take one edge, compare outputs at the next falling edge.
  task automatic step(input logic v, input logic [3:0] a, input logic [DEC_BITS-1:0] d);
    logic [W-1:0] e;
    cfg_valid = v;
    cfg_addr  = a;
    cfg_data  = d;
    @(posedge emu_clk);
    model_edge(v, a, d);
    @(negedge emu_clk);
    cfg_valid = 1'b0;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard: expected queue empty");
    end else begin
      e = exp_q.pop_front();
      check("model_outputs", dut_outputs(), e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, '0);
  endtask

  task automatic do_reset();
    logic [W-1:0] e;
    emu_rst_n = 1'b0;
    cfg_valid = 1'b0;
    cfg_addr  = 4'h0;
    cfg_data  = '0;
    repeat (2) @(posedge emu_clk);
    @(negedge emu_clk);
    e = '0;
    e[W-1] = 1'b1;
    check("reset_state", dut_outputs(), e);
    model_reset();
    emu_rst_n = 1'b1;
  endtask

  // Directed table: one row per cycle right after reset release.
  // exp_ctl = {emu_rst, emu_run, cfg_ready, dec_stb[1], dec_stb[0]}.
  typedef struct {
    logic                v;
    logic [3:0]          a;
    logic [DEC_BITS-1:0] d;
    logic [4:0]          exp_ctl;
    logic [DEC_BITS-1:0] exp_thr0;
  } vec_t;

  vec_t tbl[18];

  initial begin
    logic v;
    logic [3:0] a;
    logic [DEC_BITS-1:0] d;
    int r;
    int guard;

    tbl[0]  = '{1'b0, 4'h0, 16'h0000, 5'b10000, 16'd0};
    tbl[1]  = '{1'b0, 4'h0, 16'h0000, 5'b10000, 16'd0};
    tbl[2]  = '{1'b1, 4'h1, 16'h0007, 5'b10000, 16'd0};  // write during HOLD refused
    tbl[3]  = '{1'b0, 4'h0, 16'h0000, 5'b10000, 16'd0};
    tbl[4]  = '{1'b0, 4'h0, 16'h0000, 5'b10000, 16'd0};
    tbl[5]  = '{1'b0, 4'h0, 16'h0000, 5'b10000, 16'd0};
    tbl[6]  = '{1'b0, 4'h0, 16'h0000, 5'b10000, 16'd0};
    tbl[7]  = '{1'b0, 4'h0, 16'h0000, 5'b00100, 16'd0};  // 8th edge: IDLE
    tbl[8]  = '{1'b1, 4'h1, 16'h0003, 5'b00100, 16'd3};
    tbl[9]  = '{1'b1, 4'h0, 16'h0002, 5'b01110, 16'd3};  // RUN, count 0
    tbl[10] = '{1'b0, 4'h0, 16'h0000, 5'b01110, 16'd3};
    tbl[11] = '{1'b0, 4'h0, 16'h0000, 5'b01110, 16'd3};
    tbl[12] = '{1'b0, 4'h0, 16'h0000, 5'b01111, 16'd3};  // count 3: strobe
    tbl[13] = '{1'b0, 4'h0, 16'h0000, 5'b01110, 16'd3};
    tbl[14] = '{1'b1, 4'hF, 16'hFFFF, 5'b01110, 16'd3};  // out-of-range address
    tbl[15] = '{1'b0, 4'h0, 16'h0000, 5'b01110, 16'd3};
    tbl[16] = '{1'b0, 4'h0, 16'h0000, 5'b01111, 16'd3};
    tbl[17] = '{1'b1, 4'h0, 16'h0003, 5'b10000, 16'd3};  // soft reset keeping run

    do_reset();

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].v, tbl[i].a, tbl[i].d);
      check($sformatf("tbl%0d_ctl", i), W'({emu_rst, emu_run, cfg_ready, dec_stb}), W'(tbl[i].exp_ctl));
      check($sformatf("tbl%0d_thr0", i), W'(emu_dec_thr[DEC_BITS-1:0]), W'(tbl[i].exp_thr0));
    end

    // Soft reset from RUN: HOLD for RST_CYCLES, then RUN again with counters at 0.
    for (int i = 0; i < RST_CYCLES; i++) begin
      step(1'b0, 4'h0, '0);
      if (i < RST_CYCLES - 1) begin
        check("soft_hold_rst", W'({emu_rst, cfg_ready, dec_stb}), W'(4'b1000));
      end else begin
        check("soft_resume_run", W'({emu_rst, emu_run, dec_stb}), W'(4'b0110));
      end
    end

    // Lower the threshold under a running count: strobe next cycle, then every 3.
    step(1'b1, 4'h1, 16'd9);
    guard = 0;
    while (m_cnt[0] != 5 && guard < 30) begin
      step(1'b0, 4'h0, '0);
      guard++;
    end
    if (guard >= 30) begin
      n_checks++;
      n_fail++;
      $display("FAIL thr_lower_setup: count 5 not reached within 30 cycles");
    end
    step(1'b1, 4'h1, 16'd2);
    check("thr_lower_stb_next", W'(dec_stb[0]), W'(1));
    step(1'b0, 4'h0, '0);
    check("thr_lower_gap1", W'(dec_stb[0]), W'(0));
    step(1'b0, 4'h0, '0);
    check("thr_lower_gap2", W'(dec_stb[0]), W'(0));
    step(1'b0, 4'h0, '0);
    check("thr_lower_period3", W'(dec_stb[0]), W'(1));

    // Leave RUN mid-count and come back: the model checks the resumed count.
    step(1'b1, 4'h1, 16'd6);
    idle(2);
    step(1'b1, 4'h0, 16'h0000);
    check("idle_no_stb", W'({emu_run, cfg_ready, dec_stb}), W'(4'b0100));
    idle(3);
    step(1'b1, 4'h0, 16'h0002);
    idle(10);

    // Hardware reset mid-RUN between edges takes effect without a clock edge.
    #2;
    emu_rst_n = 1'b0;
    #1;
    check("async_rst_ctl", W'({emu_rst, emu_run, cfg_ready, dec_stb}), W'(5'b10000));
    check("async_rst_thr", W'(emu_dec_thr), W'(0));
    do_reset();
    idle(RST_CYCLES);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 2) == 0);
      r = $urandom_range(0, 9);
      if (r < 2) begin
        a = 4'h0;
        d = '0;
        d[1] = ($urandom_range(0, 3) != 0);
        d[0] = ($urandom_range(0, 15) == 0);
      end else if (r < 8) begin
        a = 4'($urandom_range(1, N_CH));
        d = DEC_BITS'($urandom_range(0, 6));
      end else begin
        a = 4'($urandom_range(N_CH + 1, 15));
        d = DEC_BITS'($urandom);
      end
      step(v, a, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/emu_ctrl_gen.md
EMU_CTRL_GEN -- requirements
Module: emu_ctrl_gen

Interface
REQ-001 Parameter: N_CH, default 2, number of decimation channels (1..15).
REQ-002 Parameter: DEC_BITS, default 16, width of each decimation threshold and counter.
REQ-003 Parameter: RST_CYCLES, default 8, emulator-reset hold length in emu_clk cycles (>=1).
REQ-004 Parameter: DEC_THR_INIT, default 0, threshold value loaded into every channel on hardware reset.
REQ-005 Port: emu_clk  input  1  emulator clock; all logic on its rising edge.
REQ-006 Port: emu_rst_n  input  1  hardware reset; one clock, reset asynchronous and active-low.
REQ-007 Port: cfg_valid  input  1  host config write request.
REQ-008 Port: cfg_ready  output  1  block accepts the write this cycle.
REQ-009 Port: cfg_addr  input  4  register address.
REQ-010 Port: cfg_data  input  DEC_BITS  write data.
REQ-011 Port: emu_rst  output  1  active-high reset to the emulated design.
REQ-012 Port: emu_run  output  1  high while in RUN state.
REQ-013 Port: emu_dec_thr  output  N_CH*DEC_BITS  current thresholds; channel k at bits [k*DEC_BITS +: DEC_BITS].
REQ-014 Port: dec_stb  output  N_CH  per-channel one-cycle decimation strobe.

Function
REQ-015 A write occurs on a rising edge with cfg_valid=1 and cfg_ready=1; cfg_ready SHALL be 1 in IDLE and RUN, 0 in HOLD.
REQ-016 Address 0 (CTRL): bit0=1 requests soft reset; bit1 sets the run request; other bits ignored.
REQ-017 Address k, 1<=k<=N_CH, SHALL write cfg_data to threshold of channel k-1, visible on emu_dec_thr the next cycle.
REQ-018 Writes to addresses above N_CH SHALL be accepted and ignored.
REQ-019 FSM states: HOLD, IDLE, RUN; all outputs registered.
REQ-020 HOLD: emu_rst=1, hold counter increments each cycle; after RST_CYCLES cycles in HOLD, go to IDLE (if run request=0) or RUN (if 1).
REQ-021 IDLE -> RUN when run request becomes 1; RUN -> IDLE when run request becomes 0; transition effective the cycle after the CTRL write.
REQ-022 Any state, CTRL write with bit0=1 -> HOLD, hold counter cleared, all channel counters cleared; run request takes bit1 of the same write; thresholds retained.
REQ-023 Per channel: counter increments only in RUN; when counter >= threshold, dec_stb[k]=1 for that cycle and counter returns to 0, else dec_stb[k]=0 and counter+1.
REQ-024 Threshold 0 in RUN SHALL give dec_stb[k]=1 every cycle; threshold T gives one strobe per T+1 cycles.
REQ-025 Threshold lowered below current counter SHALL produce a strobe on the next RUN cycle, then restart at 0 (no wrap through 2^DEC_BITS).
REQ-026 Counter arithmetic unsigned, DEC_BITS wide; counter never exceeds threshold so never overflows.
REQ-027 In IDLE and HOLD: dec_stb=0; counters hold value in IDLE, are cleared in HOLD.
REQ-028 Leaving RUN mid-count and returning SHALL resume from the held counter value.

Reset
REQ-029 emu_rst_n=0 SHALL immediately force: state HOLD, hold counter 0, run request 0, emu_rst=1, emu_run=0, cfg_ready=0, dec_stb=0, counters 0, all thresholds DEC_THR_INIT.
REQ-030 After emu_rst_n deasserts, emu_rst SHALL stay 1 for exactly RST_CYCLES rising edges, then 0 with state IDLE.
REQ-031 emu_rst_n asserted mid-RUN or mid-HOLD SHALL apply REQ-029 asynchronously, discarding any write in flight.

Verification
REQ-032 Release emu_rst_n -> emu_rst=1 for 8 cycles, then emu_rst=0, emu_run=0, cfg_ready=1, emu_dec_thr all 0.
REQ-033 Write addr1=3, addr0=0x2 -> emu_run=1 next cycle, dec_stb[0] pulses every 4 cycles, dec_stb[1] (thr 0) high every cycle.
REQ-034 During RUN with ch0 counter=5 of thr 9, write addr1=2 -> dec_stb[0] on next cycle, then every 3 cycles.
REQ-035 In RUN write addr0=0x3 -> emu_rst=1 for 8 cycles, cfg_ready=0, dec_stb=0, thresholds unchanged, then RUN resumes with counters from 0.
REQ-036 Write addr 0xF with cfg_valid held -> accepted, no output change; cfg_valid during HOLD -> not accepted until cfg_ready=1.
REQ-037 Assert emu_rst_n mid-RUN between clock edges -> emu_rst=1, dec_stb=0, emu_run=0 without waiting for an edge.
